// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - run/step/halt clock-enable generator for the slow processor clock
// Optional macro CPU_CLK_STEP_COUNT_EN adds a 16-bit wrapping count of cpu_en pulses on step_count.
module cpu_clock_ctrl #(
  parameter int          DIV_W     = 26,
  parameter int unsigned DIV_RESET = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             brk,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             brk_hit,
  output logic [15:0]      step_count
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           cur;
  logic [DIV_W-1:0] ratio;
  logic [DIV_W-1:0] count;
  logic             tick;

  // ratio is never 0, so ratio-1 cannot underflow
  assign tick  = (count == (ratio - ONE));
  assign state = cur;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      cur     <= S_HALTED;
      cpu_en  <= 1'b0;
      brk_hit <= 1'b0;
      count   <= '0;
      ratio   <= DIV_W'(DIV_RESET);
    end else begin
      cpu_en <= 1'b0;
      case (cur)
        S_HALTED: begin
          if (div_load)
            ratio <= (div_value == '0) ? ONE : div_value;
          if (halt_req) begin
            cur <= S_HALTED;
          end else if (run_req) begin
            cur     <= S_RUN;
            count   <= '0;
            brk_hit <= 1'b0;
          end else if (step_req) begin
            cur     <= S_STEP;
            count   <= '0;
            brk_hit <= 1'b0;
          end
        end

        S_RUN: begin
          // exits take priority over a tick in the same cycle, so no pulse leaks out
          if (halt_req) begin
            cur   <= S_HALTED;
            count <= '0;
          end else if (brk) begin
            cur     <= S_HALTED;
            count   <= '0;
            brk_hit <= 1'b1;
          end else if (tick) begin
            count  <= '0;
            cpu_en <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end

        S_STEP: begin
          if (halt_req) begin
            cur   <= S_HALTED;
            count <= '0;
          end else if (tick) begin
            count  <= '0;
            cpu_en <= 1'b1;
            cur    <= run_req ? S_RUN : S_HALTED;
          end else begin
            count <= count + ONE;
            if (run_req)
              cur <= S_RUN;
          end
        end

        default: begin
          cur   <= S_HALTED;
          count <= '0;
        end
      endcase
    end
  end

`ifdef CPU_CLK_STEP_COUNT_EN
  logic [15:0] step_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset)
      step_cnt_q <= '0;
    else if (cpu_en)
      step_cnt_q <= step_cnt_q + 16'd1;
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - scoreboard bench for cpu_clock_ctrl (honours CPU_CLK_STEP_COUNT_EN)
module tb_cpu_clock_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0;
  logic        step_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        brk = 1'b0;
  logic        div_load = 1'b0;
  logic [25:0] div_value = '0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        brk_hit;
  logic [15:0] step_count;

  cpu_clock_ctrl #(.DIV_W(26), .DIV_RESET(25000000)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .brk        (brk),
    .div_load   (div_load),
    .div_value  (div_value),
    .cpu_en     (cpu_en),
    .state      (state),
    .brk_hit    (brk_hit),
    .step_count (step_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic        bh;
    logic        chk_sc;
    logic [15:0] sc;
  } exp_t;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;
  bit   do_final = 0;
  bit   final_done = 0;
  int   pulse_q[$];
  exp_t state_q[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (mon_en) begin
      while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing cyc=%0d got cpu_en=0 required 1", pulse_q[0]);
        void'(pulse_q.pop_front());
      end
      if (cpu_en !== 1'b0) begin
        vectors++;
        if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
          void'(pulse_q.pop_front());
        end else begin
          miscompares++;
          $display("FAIL unexpected_pulse cyc=%0d got cpu_en=%b required 0", cyc, cpu_en);
        end
      end
      while (state_q.size() > 0 && state_q[0].cyc <= cyc) begin
        e = state_q.pop_front();
        vectors++;
        if (e.cyc != cyc || state !== e.st || brk_hit !== e.bh ||
            (e.chk_sc && step_count !== e.sc)) begin
          miscompares++;
          $display("FAIL status cyc=%0d got state=%0d brk_hit=%b step_count=%0d required state=%0d brk_hit=%b step_count=%0d",
                   e.cyc, state, brk_hit, step_count, e.st, e.bh, e.chk_sc ? e.sc : step_count);
        end
      end
      if (do_final && !final_done) begin
        vectors += 2;
        if (pulse_q.size() != 0) begin
          miscompares++;
          $display("FAIL pulse_queue_drain got %0d pending required 0", pulse_q.size());
        end
        if (state_q.size() != 0) begin
          miscompares++;
          $display("FAIL status_queue_drain got %0d pending required 0", state_q.size());
        end
        final_done = 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(negedge CLOCK_50);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next();
  endtask

  task automatic issue(input logic r, input logic s, input logic h, output int t);
    t = cyc;
    run_req = r;
    step_req = s;
    halt_req = h;
    next();
    run_req = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic load(input logic [25:0] v);
    div_load = 1'b1;
    div_value = v;
    next();
    div_load = 1'b0;
    div_value = '0;
  endtask

  task automatic exp_state(input int c, input logic [1:0] s, input logic b);
    exp_t e;
    e.cyc = c; e.st = s; e.bh = b; e.chk_sc = 1'b0; e.sc = '0;
    state_q.push_back(e);
  endtask

  task automatic exp_all(input int c, input logic [1:0] s, input logic b, input logic [15:0] sc);
    exp_t e;
    e.cyc = c; e.st = s; e.bh = b; e.chk_sc = 1'b1; e.sc = sc;
    state_q.push_back(e);
  endtask

  task automatic exp_train(input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) pulse_q.push_back(c);
  endtask

  initial begin
    int t;
    int t2;
    int dummy;
    logic [15:0] wrap_sc;

    repeat (3) next();
    reset = 1'b1;
    mon_en = 1;
    exp_all(cyc + 1, 2'd0, 1'b0, 16'd0);
    next();

    // ratio 4: pulses 5, 9, 13 after the request; halt on the tick cycle kills the 4th
    load(26'd4);
    issue(1, 0, 0, t);
    exp_state(t + 1, 2'd1, 1'b0);
    exp_train(t + 5, 4, t + 16);
    exp_state(t + 17, 2'd0, 1'b0);
    wait_until(t + 16);
    issue(0, 0, 1, dummy);
    next();

    // single step at ratio 3, then nothing for 20 cycles
    load(26'd3);
    issue(0, 1, 0, t);
    exp_state(t + 1, 2'd2, 1'b0);
    pulse_q.push_back(t + 4);
    exp_state(t + 4, 2'd0, 1'b0);
    wait_until(t + 24);

    // halt before the tick aborts the step
    issue(0, 1, 0, t);
    exp_state(t + 3, 2'd0, 1'b0);
    wait_until(t + 2);
    issue(0, 0, 1, dummy);
    wait_until(t + 8);

    // brk is ignored during a step
    issue(0, 1, 0, t);
    brk = 1'b1;
    exp_state(t + 2, 2'd2, 1'b0);
    pulse_q.push_back(t + 4);
    exp_state(t + 4, 2'd0, 1'b0);
    wait_until(t + 4);
    brk = 1'b0;
    wait_until(t + 8);

    // ratio 0 behaves as 1: pulse every cycle until brk
    load(26'd0);
    issue(1, 0, 0, t);
    exp_train(t + 2, 1, t + 6);
    exp_state(t + 7, 2'd0, 1'b1);
    exp_state(t + 9, 2'd0, 1'b1);
    wait_until(t + 6);
    brk = 1'b1;
    next();
    brk = 1'b0;
    wait_until(t + 10);

    // run clears brk_hit; step_req in RUN is ignored
    issue(1, 0, 0, t2);
    exp_state(t2 + 1, 2'd1, 1'b0);
    exp_train(t2 + 2, 1, t2 + 3);
    exp_state(t2 + 2, 2'd1, 1'b0);
    exp_state(t2 + 4, 2'd0, 1'b0);
    issue(0, 1, 0, dummy);
    wait_until(t2 + 3);
    issue(0, 0, 1, dummy);
    next();

    // all three requests together while halted: halt wins, nothing happens
    issue(1, 1, 1, t);
    exp_state(t + 1, 2'd0, 1'b0);
    exp_state(t + 3, 2'd0, 1'b0);
    wait_until(t + 5);

    // ratio 2; div_load 7 during RUN must not change spacing
    load(26'd2);
    issue(1, 0, 0, t);
    exp_train(t + 3, 2, t + 9);
    exp_state(t + 10, 2'd0, 1'b0);
    wait_until(t + 2);
    load(26'd7);
    wait_until(t + 9);
    issue(0, 0, 1, dummy);
    next();

    // run_req during STEP converts it to RUN without restarting the count
    issue(0, 1, 0, t);
    exp_state(t + 2, 2'd1, 1'b0);
    exp_state(t + 3, 2'd1, 1'b0);
    exp_train(t + 3, 2, t + 6);
    exp_state(t + 7, 2'd0, 1'b0);
    issue(1, 0, 0, dummy);
    wait_until(t + 6);
    issue(0, 0, 1, dummy);
    next();

    // reset on the tick cycle: no pulse, outputs at reset values
    issue(1, 0, 0, t);
    exp_all(t + 3, 2'd0, 1'b0, 16'd0);
    exp_all(t + 4, 2'd0, 1'b0, 16'd0);
    wait_until(t + 2);
    reset = 1'b0;
    next();
    reset = 1'b1;
    wait_until(t + 6);

    // 70000 pulses at ratio 1: step_count wraps to 70000 mod 65536 = 4464
`ifdef CPU_CLK_STEP_COUNT_EN
    wrap_sc = 16'd4464;
`else
    wrap_sc = 16'd0;
`endif
    load(26'd0);
    issue(1, 0, 0, t);
    exp_train(t + 2, 1, t + 70001);
    exp_all(t + 70003, 2'd0, 1'b0, wrap_sc);
    wait_until(t + 70001);
    issue(0, 0, 1, dummy);
    wait_until(t + 70006);

    do_final = 1;
    for (int i = 0; i < 4 && !final_done; i++) next();
    if (!final_done) begin
      miscompares++;
      vectors++;
      $display("FAIL final_check got not_done required done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
